// File: rtl/inv_mixcol_seq.sv
// Column-serial AES InvMixColumns: one 32-bit column unit shared across the
// four state columns, with valid/ready on both sides and a final-round bypass.
module inv_mixcol_seq (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [0:127]  in_state,
   input  logic          in_bypass,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [0:127]  out_state,
   output logic          busy,
   output logic [15:0]   blk_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid holds its payload until then and never waits on ready.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [1:0]    col;
   logic [0:127]  in_reg;
   logic          byp_reg;
   logic [31:0]   col_in, col_mix, col_out;
   logic [7:0]    a, b, c, d;

   function automatic logic [7:0] xt(input logic [7:0] x);
      xt = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] x);
      mul9 = xt(xt(xt(x))) ^ x;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] x);
      mulb = xt(xt(xt(x))) ^ xt(x) ^ x;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] x);
      muld = xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] x);
      mule = xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
   endfunction

   // The single column unit, fed from the column selected by col.
   always_comb begin
      col_in  = in_reg[{col, 5'b0} +: 32];
      a       = col_in[31:24];
      b       = col_in[23:16];
      c       = col_in[15:8];
      d       = col_in[7:0];
      col_mix = {mule(a) ^ mulb(b) ^ muld(c) ^ mul9(d),
                 mule(b) ^ mulb(c) ^ muld(d) ^ mul9(a),
                 mule(c) ^ mulb(d) ^ muld(a) ^ mul9(b),
                 mule(d) ^ mulb(a) ^ muld(b) ^ mul9(c)};
      col_out = byp_reg ? col_in : col_mix;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (col == 2'd3) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= 2'd0;
         in_reg    <= '0;
         byp_reg   <= 1'b0;
         out_state <= '0;
         blk_count <= 16'd0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_reg  <= in_state;
                  byp_reg <= in_bypass;
                  col     <= 2'd0;
               end
            end
            RUN: begin
               out_state[{col, 5'b0} +: 32] <= col_out;
               col <= col + 2'd1;
            end
            DONE: begin
               if (out_ready && blk_count != 16'hffff) blk_count <= blk_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Bench for inv_mixcol_seq: directed vectors plus random blocks, checked
// against a byte-wise GF(2^8) model of InvMixColumns.
module tb_inv_mixcol_seq;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [0:127]  in_state = '0;
   logic          in_bypass = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [0:127]  out_state;
   logic          busy;
   logic [15:0]   blk_count;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_cnt = 0;
   logic [127:0] exp_q[$];

   inv_mixcol_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid),
      .out_ready(out_ready), .out_state(out_state), .busy(busy), .blk_count(blk_count)
   );

   always #5 clk = ~clk;

   // Shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [0:127] model(input logic [0:127] s, input logic byp);
      logic [0:127] r;
      logic [7:0] v [4];
      logic [7:0] cf [4];
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
      r = s;
      if (!byp) begin
         for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) v[k] = s[8*(4*c+k) +: 8];
            for (int row = 0; row < 4; row++) begin
               logic [7:0] acc;
               acc = 8'h00;
               for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[j], v[(row+j)%4]);
               r[8*(4*c+row) +: 8] = acc;
            end
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bump_cnt();
      if (exp_cnt < 65535) exp_cnt++;
   endtask

   // Drives one block; returns once the accepting edge has passed.
   task automatic send(input logic [0:127] s, input logic byp);
      int n;
      in_state = s;
      in_bypass = byp;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      tests_run++;
      if (!in_ready) begin
         tests_failed++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests_run++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_state !== 128'h0 || blk_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_values: rdy=%0b vld=%0b busy=%0b st=%h cnt=%0d required 1 0 0 0 0",
                  in_ready, out_valid, busy, out_state, blk_count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic test_latency(input logic [0:127] s, input logic byp, input string name);
      logic [0:127] exp;
      exp = model(s, byp);
      out_ready = 1'b1;
      send(s, byp);
      for (int i = 1; i <= 4; i++) begin
         tick();
         tests_run++;
         if (out_valid !== (i == 4)) begin
            tests_failed++;
            $display("FAIL %s_latency_e%0d: out_valid=%0b required %0b", name, i, out_valid, (i == 4));
         end
      end
      tests_run++;
      if (out_state !== exp) begin
         tests_failed++;
         $display("FAIL %s_data: out_state=%h required %h", name, out_state, exp);
      end
      tick();
      bump_cnt();
      tests_run++;
      if (blk_count !== exp_cnt[15:0] || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_handshake: cnt=%0d rdy=%0b vld=%0b required %0d 1 0",
                  name, blk_count, in_ready, out_valid, exp_cnt);
      end
   endtask

   task automatic test_known_vectors();
      logic [0:127] v;
      test_latency(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, "vec_mix");
      tests_run++;
      if (model(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0) !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
         tests_failed++;
         $display("FAIL model_selfcheck: model disagrees with published vector");
      end
      v = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      test_latency(v, 1'b1, "vec_bypass");
   endtask

   task automatic test_hold();
      logic [0:127] s1, s2, held;
      s1 = {$urandom, $urandom, $urandom, $urandom};
      s2 = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      send(s1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      held = out_state;
      tests_run++;
      if (out_valid !== 1'b1 || held !== model(s1, 1'b0)) begin
         tests_failed++;
         $display("FAIL hold_first: vld=%0b st=%h required 1 %h", out_valid, held, model(s1, 1'b0));
      end
      in_state = s2;
      in_bypass = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== held) begin
            tests_failed++;
            $display("FAIL hold_stall_%0d: vld=%0b rdy=%0b st=%h required 1 0 %h",
                     i, out_valid, in_ready, out_state, held);
         end
      end
      out_ready = 1'b1;
      tick();
      bump_cnt();
      tests_run++;
      if (in_ready !== 1'b1 || blk_count !== exp_cnt[15:0]) begin
         tests_failed++;
         $display("FAIL hold_release: rdy=%0b cnt=%0d required 1 %0d", in_ready, blk_count, exp_cnt);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL hold_next_accept: busy=%0b rdy=%0b required 1 0", busy, in_ready);
      end
      for (int i = 0; i < 4; i++) tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_state !== model(s2, 1'b0)) begin
         tests_failed++;
         $display("FAIL hold_second: vld=%0b st=%h required 1 %h", out_valid, out_state, model(s2, 1'b0));
      end
      tick();
      bump_cnt();
   endtask

   task automatic test_reset_mid_block();
      logic seen;
      out_ready = 1'b1;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      tests_run++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_state !== 128'h0 || blk_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL midreset_values: rdy=%0b vld=%0b busy=%0b st=%h cnt=%0d required 1 0 0 0 0",
                  in_ready, out_valid, busy, out_state, blk_count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_no_output: seen_valid=%0b rdy=%0b required 0 1", seen, in_ready);
      end
      test_latency({4{32'hd5d5d7d6}}, 1'b0, "after_reset");
      tests_run++;
      if (model({4{32'hd5d5d7d6}}, 1'b0) !== {4{32'hd4d4d4d5}}) begin
         tests_failed++;
         $display("FAIL model_selfcheck2: model disagrees with d5d5d7d6 vector");
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         test_latency({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [0:127] blk [3];
      logic         byp [3];
      int acc_cyc [3];
      int n_in, n_out, cyc;
      logic acc, hs;
      for (int i = 0; i < 3; i++) begin
         blk[i] = {$urandom, $urandom, $urandom, $urandom};
         byp[i] = (i == 1);
         exp_q.push_back(model(blk[i], byp[i]));
      end
      n_in = 0;
      n_out = 0;
      cyc = 0;
      out_ready = 1'b1;
      in_state = blk[0];
      in_bypass = byp[0];
      in_valid = 1'b1;
      while (n_out < 3 && cyc < 60) begin
         acc = in_valid && in_ready;
         hs = out_valid;
         if (hs) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (out_state !== e) begin
               tests_failed++;
               $display("FAIL b2b_data_%0d: out_state=%h required %h", n_out, out_state, e);
            end
            n_out++;
            bump_cnt();
         end
         tick();
         cyc++;
         if (acc) begin
            acc_cyc[n_in] = cyc;
            n_in++;
            if (n_in < 3) begin
               in_state = blk[n_in];
               in_bypass = byp[n_in];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if (n_out != 3 || n_in != 3) begin
         tests_failed++;
         $display("FAIL b2b_timeout: accepted=%0d delivered=%0d required 3 3", n_in, n_out);
      end else begin
         for (int i = 1; i < 3; i++) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
               tests_failed++;
               $display("FAIL b2b_spacing_%0d: gap=%0d required 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
         end
      end
      tick();
      tests_run++;
      if (blk_count !== exp_cnt[15:0]) begin
         tests_failed++;
         $display("FAIL b2b_count: cnt=%0d required %0d", blk_count, exp_cnt);
      end
      exp_q.delete();
   endtask

   task automatic test_b2b_count_from_reset();
      test_reset();
      test_back_to_back();
      tests_run++;
      if (blk_count !== 16'd3) begin
         tests_failed++;
         $display("FAIL b2b_count_abs: cnt=%0d required 3", blk_count);
      end
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_hold();
      test_random();
      test_reset_mid_block();
      test_b2b_count_from_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
